// File: rtl/mpi_bus_pkg.sv
// Shared MPI (Q-bus style) definitions: FSM state encoding, active-low bus
// polarity helpers and bus timing constants.
// Used by mpi_reg_slave and mpi_sync2.
package mpi_bus_pkg;

    // Register-slave FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACTIVE   = 3'd1,
        ST_RD_DRV   = 3'd2,
        ST_RD_DLY   = 3'd3,
        ST_WR_DLY   = 3'd4,
        ST_REPLY    = 3'd5,
        ST_WAIT_END = 3'd6
    } state_t;

    // All MPI control lines are active-low
    localparam logic BUS_ASSERT   = 1'b0;
    localparam logic BUS_DEASSERT = 1'b1;

    // Master gives up on a cycle after this many CLKp without nRPLY
    localparam int RPLY_TIMEOUT = 64;
    // Flops per control-line synchroniser
    localparam int SYNC_DEPTH   = 2;
    // Width of the reply delay counter (RPLY_DLY range 0..15)
    localparam int DLY_W        = 4;

    // Merge one byte of new_word into old_word; hi_byte selects [15:8]
    function automatic logic [15:0] byte_merge(input logic [15:0] old_word,
                                               input logic [15:0] new_word,
                                               input logic        hi_byte);
        logic [15:0] merged;
        merged = old_word;
        if (hi_byte) begin
            merged[15:8] = new_word[15:8];
        end else begin
            merged[7:0] = new_word[7:0];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mpi_sync2.sv
// Multi-flop synchroniser for one asynchronous MPI control line.
// Resets to the inactive (high) level so the FSM sees an idle bus.
module mpi_sync2
    import mpi_bus_pkg::*;
#(
    parameter logic RST_VAL = BUS_DEASSERT
) (
    input  logic CLKp,
    input  logic nRSTp,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] sync_reg;

    // Shift the raw line through SYNC_DEPTH flops
    always_ff @(posedge CLKp or negedge nRSTp) begin
        if (!nRSTp) begin
            sync_reg <= {SYNC_DEPTH{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = sync_reg[SYNC_DEPTH-1];

endmodule

// File: rtl/mpi_reg_slave.sv
// MPI (Q-bus style) register slave: NREG 16-bit registers at BASE_ADDR,
// word/byte write, word read and read-modify-write, open-drain nRPLY.
// Optional: define MPI_SLAVE_BYTE_EN to honour byte writes (nWTBT in the
// data phase); without it every write updates the full word.
module mpi_reg_slave
    import mpi_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'o177660,
    parameter int          NREG      = 4,
    parameter int          RPLY_DLY  = 1
) (
    input  logic                CLKp,
    input  logic                nRSTp,
    inout  wire  [15:0]         nADp,
    input  logic                nSYNCp,
    input  logic                nDINp,
    input  logic                nDOUTp,
    input  logic                nWTBTp,
    inout  wire                 nRPLYp,
    output logic [16*NREG-1:0]  regs_q,
    output logic [NREG-1:0]     wr_stb,
    output logic                sel
);

    // Address bits covered by the register block (byte address)
    localparam int ABITS = $clog2(2 * NREG);
    localparam int IDXW  = (NREG > 1) ? $clog2(NREG) : 1;

    // ------------------------------------------------------------------
    // Address phase capture
    // ------------------------------------------------------------------
    logic [15:0] a_lat_reg;
    logic        wcyc_reg;

    // Latch address and cycle type on the falling nSYNC edge; the master
    // removes the address too soon for a CLKp-synchronised capture.
    always_ff @(negedge nSYNCp or negedge nRSTp) begin
        if (!nRSTp) begin
            a_lat_reg <= '0;
            wcyc_reg  <= 1'b0;
        end else begin
            a_lat_reg <= ~nADp;
            wcyc_reg  <= ~nWTBTp;
        end
    end

    // ------------------------------------------------------------------
    // Control-line synchronisers
    // ------------------------------------------------------------------
    logic sync_s;
    logic din_s;
    logic dout_s;

    mpi_sync2 u_sync_sync (.CLKp(CLKp), .nRSTp(nRSTp), .d(nSYNCp), .q(sync_s));
    mpi_sync2 u_sync_din  (.CLKp(CLKp), .nRSTp(nRSTp), .d(nDINp),  .q(din_s));
    mpi_sync2 u_sync_dout (.CLKp(CLKp), .nRSTp(nRSTp), .d(nDOUTp), .q(dout_s));

`ifdef MPI_SLAVE_BYTE_EN
    logic wtbt_s;
    mpi_sync2 u_sync_wtbt (.CLKp(CLKp), .nRSTp(nRSTp), .d(nWTBTp), .q(wtbt_s));
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic            hit;
    logic [IDXW-1:0] idx;

    assign hit = (a_lat_reg[15:ABITS] == BASE_ADDR[15:ABITS]);

    generate
        if (NREG > 1) begin : g_idx
            assign idx = a_lat_reg[ABITS-1:1];
        end else begin : g_idx_single
            assign idx = '0;
        end
    endgenerate

    // Cycle type and, in word-only builds, the byte address bit are not
    // needed for decoding; collected here so they are visibly accounted for.
    logic unused_bits;
    assign unused_bits = ^{wcyc_reg, a_lat_reg[0]};

    // ------------------------------------------------------------------
    // Register file and FSM state
    // ------------------------------------------------------------------
    logic [15:0]      regs_reg [NREG];
    logic [NREG-1:0]  wr_stb_reg;
    state_t           state_reg;
    logic [DLY_W-1:0] cnt_reg;
    logic             sel_reg;
    logic             rply_reg;
    logic             ad_oe_reg;
    logic [15:0]      ad_out_reg;

    logic [15:0] wr_data;
    logic [15:0] wr_word_next;

    assign wr_data = ~nADp;

    // Value written into reg[idx] on the WR_DLY -> REPLY transition
    always_comb begin
        wr_word_next = wr_data;
`ifdef MPI_SLAVE_BYTE_EN
        if (wtbt_s == BUS_ASSERT) begin
            wr_word_next = byte_merge(regs_reg[idx], wr_data, a_lat_reg[0]);
        end
`endif
    end

    // Bus-cycle FSM with registered bus drives, strobes and register updates
    always_ff @(posedge CLKp or negedge nRSTp) begin
        if (!nRSTp) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            sel_reg    <= 1'b0;
            rply_reg   <= 1'b0;
            ad_oe_reg  <= 1'b0;
            ad_out_reg <= '1;
            wr_stb_reg <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            wr_stb_reg <= '0;
            if ((state_reg != ST_IDLE) && (sync_s == BUS_DEASSERT)) begin
                // Master ended (or abandoned) the cycle: let go of the bus now
                state_reg <= ST_IDLE;
                sel_reg   <= 1'b0;
                rply_reg  <= 1'b0;
                ad_oe_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if ((sync_s == BUS_ASSERT) && hit) begin
                            state_reg <= ST_ACTIVE;
                            sel_reg   <= 1'b1;
                        end
                    end
                    ST_ACTIVE, ST_WAIT_END: begin
                        // Read wins if both strobes are (illegally) active
                        if (din_s == BUS_ASSERT) begin
                            state_reg <= ST_RD_DRV;
                        end else if (dout_s == BUS_ASSERT) begin
                            state_reg <= ST_WR_DLY;
                            cnt_reg   <= DLY_W'(RPLY_DLY);
                        end
                    end
                    ST_RD_DRV: begin
                        ad_out_reg <= ~regs_reg[idx];
                        ad_oe_reg  <= 1'b1;
                        cnt_reg    <= DLY_W'(RPLY_DLY);
                        state_reg  <= ST_RD_DLY;
                    end
                    ST_RD_DLY: begin
                        if (cnt_reg == '0) begin
                            state_reg <= ST_REPLY;
                            rply_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - DLY_W'(1);
                        end
                    end
                    ST_WR_DLY: begin
                        if (cnt_reg == '0) begin
                            state_reg       <= ST_REPLY;
                            rply_reg        <= 1'b1;
                            regs_reg[idx]   <= wr_word_next;
                            wr_stb_reg[idx] <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - DLY_W'(1);
                        end
                    end
                    ST_REPLY: begin
                        if ((din_s == BUS_DEASSERT) && (dout_s == BUS_DEASSERT)) begin
                            rply_reg  <= 1'b0;
                            ad_oe_reg <= 1'b0;
                            state_reg <= ST_WAIT_END;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        sel_reg   <= 1'b0;
                        rply_reg  <= 1'b0;
                        ad_oe_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign nADp   = ad_oe_reg ? ad_out_reg : 16'hzzzz;
    assign nRPLYp = rply_reg ? BUS_ASSERT : 1'bz;
    assign wr_stb = wr_stb_reg;
    assign sel    = sel_reg;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_regs_q
            assign regs_q[16*gi +: 16] = regs_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mpi_reg_slave.sv
// Directed bench for mpi_reg_slave: table of single bus cycles plus
// hand-written RMW and reset-during-reply sequences.
module tb_mpi_reg_slave;
    import mpi_bus_pkg::*;

    localparam logic [15:0] BASE = 16'o177660;
    localparam int NREG = 4;
    localparam int RPLY_DLY = 1;

    logic        CLKp = 1'b0;
    logic        nRSTp = 1'b0;
    tri1  [15:0] nADp;
    tri1         nRPLYp;
    logic        nSYNCp = 1'b1;
    logic        nDINp = 1'b1;
    logic        nDOUTp = 1'b1;
    logic        nWTBTp = 1'b1;
    logic [63:0] regs_q;
    logic [3:0]  wr_stb;
    logic        sel;

    logic [15:0] m_ad = '0;
    logic        m_oe = 1'b0;
    assign nADp = m_oe ? m_ad : 16'hzzzz;

    mpi_reg_slave #(.BASE_ADDR(BASE), .NREG(NREG), .RPLY_DLY(RPLY_DLY)) dut (
        .CLKp(CLKp), .nRSTp(nRSTp), .nADp(nADp), .nSYNCp(nSYNCp), .nDINp(nDINp),
        .nDOUTp(nDOUTp), .nWTBTp(nWTBTp), .nRPLYp(nRPLYp), .regs_q(regs_q),
        .wr_stb(wr_stb), .sel(sel)
    );

    always #5 CLKp = ~CLKp;

    int total = 0;
    int bad = 0;

    // Cumulative monitors sampled on the inactive edge
    int   stb_cnt [4] = '{0, 0, 0, 0};
    int   rply_falls = 0;
    int   sel_hi = 0;
    logic rply_prev = 1'b1;
    always @(negedge CLKp) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_stb[i] === 1'b1) stb_cnt[i] <= stb_cnt[i] + 1;
        end
        if (rply_prev === 1'b1 && nRPLYp === 1'b0) rply_falls <= rply_falls + 1;
        if (sel === 1'b1) sel_hi <= sel_hi + 1;
        rply_prev <= nRPLYp;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rply(input logic lvl, output int cyc, output logic ok,
                             output logic [15:0] prev_ad);
        cyc = 0;
        ok = 1'b0;
        prev_ad = nADp;
        while (cyc < RPLY_TIMEOUT && !ok) begin
            @(posedge CLKp);
            #1;
            cyc++;
            if (nRPLYp === lvl) ok = 1'b1;
            else prev_ad = nADp;
        end
    endtask

    task automatic addr_phase(input logic [15:0] a, input logic wr);
        @(negedge CLKp);
        m_ad = ~a; m_oe = 1'b1; nWTBTp = wr ? 1'b0 : 1'b1;
        @(negedge CLKp);
        nSYNCp = 1'b0;
        @(negedge CLKp);
        m_oe = 1'b0; nWTBTp = 1'b1;
    endtask

    task automatic data_write(input logic [15:0] d, input logic byte_f,
                              output int lat, output logic ok);
        int c2; logic ok2; logic [15:0] pa;
        @(negedge CLKp);
        m_ad = ~d; m_oe = 1'b1; nWTBTp = byte_f ? 1'b0 : 1'b1; nDOUTp = 1'b0;
        wait_rply(1'b0, lat, ok, pa);
        @(negedge CLKp);
        nDOUTp = 1'b1; m_oe = 1'b0; nWTBTp = 1'b1;
        if (ok) wait_rply(1'b1, c2, ok2, pa);
    endtask

    task automatic data_read(output logic [15:0] rd, output logic lead_ok,
                             output logic rel_ok, output logic ok);
        int c; logic ok2; logic [15:0] pa;
        @(negedge CLKp);
        nDINp = 1'b0;
        wait_rply(1'b0, c, ok, pa);
        rd = ~nADp;
        lead_ok = (pa === nADp);
        @(negedge CLKp);
        nDINp = 1'b1;
        rel_ok = 1'b0;
        if (ok) begin
            wait_rply(1'b1, c, ok2, pa);
            rel_ok = ok2 && (nADp === 16'hFFFF);
        end else begin
            rel_ok = (nADp === 16'hFFFF);
        end
    endtask

    task automatic end_cycle();
        @(negedge CLKp);
        nSYNCp = 1'b1;
        repeat (4) @(negedge CLKp);
    endtask

    typedef struct {
        logic        wr;
        logic        byte_f;
        logic [15:0] addr;
        logic [15:0] data;
        logic        hit;
        logic [15:0] exp;
    } vec_t;

`ifdef MPI_SLAVE_BYTE_EN
    localparam logic [15:0] EXP_R0_BYTE = 16'h5534;
    localparam logic [15:0] EXP_R2_BYTE = 16'h00AA;
`else
    localparam logic [15:0] EXP_R0_BYTE = 16'h5500;
    localparam logic [15:0] EXP_R2_BYTE = 16'h77AA;
`endif

    vec_t vecs [11];
    logic [15:0] model [4];

    function automatic logic [63:0] model_word();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    initial begin
        int lat; logic ok, lead_ok, rel_ok; logic [15:0] rd;
        int s_before [4]; int f_before; int sel_before; int ridx;

        vecs[0]  = '{1'b1, 1'b0, BASE + 16'd2, 16'o000017, 1'b1, 16'o000017};
        vecs[1]  = '{1'b1, 1'b0, BASE + 16'd0, 16'h1234,   1'b1, 16'h1234};
        vecs[2]  = '{1'b1, 1'b1, BASE + 16'd1, 16'h5500,   1'b1, EXP_R0_BYTE};
        vecs[3]  = '{1'b1, 1'b0, BASE + 16'd6, 16'hA5C3,   1'b1, 16'hA5C3};
        vecs[4]  = '{1'b0, 1'b0, BASE + 16'd6, 16'h0000,   1'b1, 16'hA5C3};
        vecs[5]  = '{1'b0, 1'b0, BASE + 16'd2, 16'h0000,   1'b1, 16'o000017};
        vecs[6]  = '{1'b1, 1'b1, BASE + 16'd4, 16'h77AA,   1'b1, EXP_R2_BYTE};
        vecs[7]  = '{1'b0, 1'b0, BASE + 16'd0, 16'h0000,   1'b1, EXP_R0_BYTE};
        vecs[8]  = '{1'b1, 1'b0, 16'o177714,   16'h1111,   1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 16'o177714,   16'h0000,   1'b0, 16'h0000};
        vecs[10] = '{1'b0, 1'b0, BASE + 16'd4, 16'h0000,   1'b1, EXP_R2_BYTE};
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;

        // Reset state, during and after reset
        repeat (3) @(negedge CLKp);
        chk("rst_regs", regs_q, 64'h0);
        chk("rst_rply", {63'h0, nRPLYp}, 64'h1);
        chk("rst_ad", {48'h0, nADp}, 64'hFFFF);
        chk("rst_sel", {63'h0, sel}, 64'h0);
        nRSTp = 1'b1;
        repeat (3) @(negedge CLKp);
        chk("idle_stb", {60'h0, wr_stb}, 64'h0);
        chk("idle_sel", {63'h0, sel}, 64'h0);

        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < 4; i++) s_before[i] = stb_cnt[i];
            sel_before = sel_hi;
            ridx = int'(vecs[v].addr[2:1]);
            addr_phase(vecs[v].addr, vecs[v].wr);
            if (vecs[v].wr) begin
                data_write(vecs[v].data, vecs[v].byte_f, lat, ok);
                chk($sformatf("v%0d_reply", v), {63'h0, ok}, {63'h0, vecs[v].hit});
                if (vecs[v].hit) begin
                    chk($sformatf("v%0d_wr_lat_le5(lat=%0d)", v, lat),
                        {63'h0, (lat <= 5)}, 64'h1);
                    model[ridx] = vecs[v].exp;
                end
            end else begin
                data_read(rd, lead_ok, rel_ok, ok);
                chk($sformatf("v%0d_reply", v), {63'h0, ok}, {63'h0, vecs[v].hit});
                chk($sformatf("v%0d_release", v), {63'h0, rel_ok}, 64'h1);
                if (vecs[v].hit) begin
                    chk($sformatf("v%0d_rdata", v), {48'h0, rd}, {48'h0, vecs[v].exp});
                    chk($sformatf("v%0d_lead", v), {63'h0, lead_ok}, 64'h1);
                end
            end
            end_cycle();
            chk($sformatf("v%0d_regs", v), regs_q, model_word());
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d_stb%0d", v, i), 64'(stb_cnt[i] - s_before[i]),
                    (vecs[v].wr && vecs[v].hit && i == ridx) ? 64'd1 : 64'd0);
            end
            chk($sformatf("v%0d_sel_end", v), {63'h0, sel}, 64'h0);
            if (!vecs[v].hit)
                chk($sformatf("v%0d_sel_never", v), 64'(sel_hi - sel_before), 64'd0);
        end

        // Read-modify-write of reg2 under one nSYNC
        for (int i = 0; i < 4; i++) s_before[i] = stb_cnt[i];
        f_before = rply_falls;
        addr_phase(BASE + 16'd4, 1'b0);
        data_read(rd, lead_ok, rel_ok, ok);
        chk("rmw_rd_reply", {63'h0, ok}, 64'h1);
        chk("rmw_rd_old", {48'h0, rd}, {48'h0, EXP_R2_BYTE});
        data_write(16'hFFFF, 1'b0, lat, ok);
        chk("rmw_wr_reply", {63'h0, ok}, 64'h1);
        end_cycle();
        model[2] = 16'hFFFF;
        chk("rmw_regs", regs_q, model_word());
        chk("rmw_rply_pulses", 64'(rply_falls - f_before), 64'd2);
        chk("rmw_stb2", 64'(stb_cnt[2] - s_before[2]), 64'd1);

        // Asynchronous reset while replying to a read of reg3
        addr_phase(BASE + 16'd6, 1'b0);
        @(negedge CLKp);
        nDINp = 1'b0;
        wait_rply(1'b0, lat, ok, rd);
        chk("rstrp_reply", {63'h0, ok}, 64'h1);
        chk("rstrp_driving", {48'h0, nADp}, {48'h0, ~16'hA5C3});
        #2;
        nRSTp = 1'b0;
        #1;
        chk("rstrp_rply_rel", {63'h0, nRPLYp}, 64'h1);
        chk("rstrp_ad_rel", {48'h0, nADp}, 64'hFFFF);
        chk("rstrp_regs", regs_q, 64'h0);
        chk("rstrp_sel", {63'h0, sel}, 64'h0);
        @(negedge CLKp);
        nDINp = 1'b1; nSYNCp = 1'b1;
        repeat (3) @(negedge CLKp);
        nRSTp = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = 16'h0000;
        repeat (2) @(negedge CLKp);

        // Normal cycles after reset release
        addr_phase(BASE + 16'd6, 1'b1);
        data_write(16'h0F0F, 1'b0, lat, ok);
        chk("post_wr_reply", {63'h0, ok}, 64'h1);
        end_cycle();
        model[3] = 16'h0F0F;
        chk("post_regs", regs_q, model_word());
        addr_phase(BASE + 16'd6, 1'b0);
        data_read(rd, lead_ok, rel_ok, ok);
        chk("post_rd_reply", {63'h0, ok}, 64'h1);
        chk("post_rdata", {48'h0, rd}, 64'h0F0F);
        end_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
